// File: rtl/mul_add_seq_if.sv
// Operand/result bundle for mul_add_seq: operand handshake in, reconstructed
// nominator and consistency flag out.
interface mul_add_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  q_in;
  logic [5:0]  d_in;
  logic [5:0]  r_in;
  logic [13:0] n_out;
  logic        out_valid;
  logic        err_out;

  modport master (
    output in_valid, q_in, d_in, r_in,
    input  in_ready, n_out, out_valid, err_out
  );

  modport slave (
    input  in_valid, q_in, d_in, r_in,
    output in_ready, n_out, out_valid, err_out
  );
endinterface

// File: rtl/mul_add_seq.sv
// Shift-add multiply-accumulate rebuilding n = q * d + r, one quotient bit per clock.
// Optional remainder/zero-divisor consistency check enabled by MUL_ADD_CHECK_EN.
//
// state | meaning
// IDLE  | ready; operands captured on in_valid
// ADD   | 8 cycles, one quotient bit each, acc += dd when qq[0]
// OUT   | result and flag registered, out_valid pulsed
module mul_add_seq (
  input  logic         clk,
  input  logic         reset_n,
  mul_add_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        accept;
  logic [2:0]  count;
  logic [7:0]  qq;
  logic [13:0] dd;
  logic [13:0] acc;
  logic [13:0] n_r;
  logic        out_valid_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = ADD;
        end
      end
      ADD:     if (count == 3'd7) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // 255*63+63 fits in 14 bits, so the accumulator needs no carry-out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= 3'd0;
      qq          <= 8'd0;
      dd          <= 14'd0;
      acc         <= 14'd0;
      n_r         <= 14'd0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            qq    <= bus.q_in;
            dd    <= {8'b0, bus.d_in};
            acc   <= {8'b0, bus.r_in};
            count <= 3'd0;
          end
        end
        ADD: begin
          if (qq[0]) acc <= acc + dd;
          qq    <= qq >> 1;
          dd    <= dd << 1;
          count <= count + 3'd1;
        end
        OUT: begin
          n_r         <= acc;
          out_valid_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MUL_ADD_CHECK_EN
  logic chk;
  logic err_r;
  logic err_q;

  // Flags a non-canonical remainder or a divide-by-zero source.
  assign chk = (bus.d_in == 6'd0) | (bus.r_in >= bus.d_in);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept)        err_r <= chk;
      if (state == OUT)  err_q <= err_r;
    end
  end

  assign bus.err_out = err_q;
`else
  assign bus.err_out = 1'b0;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.n_out     = n_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_mul_add_seq.sv
// Scoreboard bench for mul_add_seq: driver pushes hand-computed results with
// the cycle they are due; a negedge monitor pops and compares on out_valid.
module tb_mul_add_seq;

`ifdef MUL_ADD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  typedef struct {
    logic [13:0] n;
    logic        e;
    int          c;
  } exp_t;

  exp_t sbq[$];

  mul_add_seq_if bus ();

  mul_add_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every out_valid must match the oldest expected entry, on time.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("n_out", int'(bus.n_out), int'(e.n));
        check("err_out", int'(bus.err_out), int'(e.e));
        check("out_cycle", cyc, e.c);
      end
    end
  end

  // Waits (bounded) for in_ready, presents one operand set for one edge.
  task automatic send(input logic [7:0] q, input logic [5:0] d, input logic [5:0] r,
                      input logic [13:0] n_exp, input logic flag, input bit push);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.q_in = q;
    bus.d_in = d;
    bus.r_in = r;
    @(posedge clk);
    #1;
    if (push) begin
      e.n = n_exp;
      e.e = CHK & flag;
      e.c = cyc + 9;
      sbq.push_back(e);
    end
    bus.in_valid = 1'b0;
    bus.q_in = 8'hFF;
    bus.d_in = 6'h3F;
    bus.r_in = 6'h3F;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("drain_queue_empty", sbq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    n_tests = 0;
    n_fail = 0;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.q_in = 8'd0;
    bus.d_in = 6'd0;
    bus.r_in = 6'd0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_n_out", int'(bus.n_out), 0);
    check("rst_err_out", int'(bus.err_out), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(bus.in_ready), 1);

    send(8'd4,   6'd50, 6'd34, 14'd234,   1'b0, 1'b1);
    drain();
    send(8'd255, 6'd63, 6'd62, 14'd16127, 1'b0, 1'b1);
    send(8'd0,   6'd0,  6'd0,  14'd0,     1'b1, 1'b1);
    send(8'd0,   6'd0,  6'd5,  14'd5,     1'b1, 1'b1);
    send(8'd3,   6'd10, 6'd12, 14'd42,    1'b1, 1'b1);
    drain();

    // in_valid held high with operands changing every cycle.
    @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      bus.in_valid = 1'b1;
      case (k)
        0:  begin bus.q_in = 8'd5;   bus.d_in = 6'd9;  bus.r_in = 6'd3;  end
        10: begin bus.q_in = 8'd100; bus.d_in = 6'd20; bus.r_in = 6'd7;  end
        20: begin bus.q_in = 8'd17;  bus.d_in = 6'd33; bus.r_in = 6'd40; end
        default: begin
          bus.q_in = 8'(200 + k);
          bus.d_in = 6'(k + 1);
          bus.r_in = 6'(63 - k);
        end
      endcase
      @(posedge clk);
      #1;
      if (k == 0 || k == 10 || k == 20) begin
        exp_t e;
        e.c = cyc + 9;
        case (k)
          0:       begin e.n = 14'd48;   e.e = 1'b0;      end
          10:      begin e.n = 14'd2007; e.e = 1'b0;      end
          default: begin e.n = 14'd601;  e.e = CHK;       end
        endcase
        sbq.push_back(e);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    drain();

    // Reset mid-ADD drops the transaction.
    send(8'd9, 6'd9, 6'd1, 14'd0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_n_out", int'(bus.n_out), 0);
    check("midrst_err_out", int'(bus.err_out), 0);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("release_in_ready", int'(bus.in_ready), 1);
    send(8'd2, 6'd7, 6'd1, 14'd15, 1'b0, 1'b1);
    drain();
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
